// File: rtl/cpm_pkg.sv
// Shared types and default constants for the multi-channel CPM output sequencer.
package cpm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } cpm_state_t;

  localparam int DEF_DATA_W    = 22;
  localparam int DEF_N_CH      = 4;
  localparam int DEF_SETUP_CYC = 100;
  localparam int DEF_HOLD_CYC  = 1946;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpm_output_seq_if.sv
// CPM bus: data+strobe word and channel index from the sequencer, ack from the consumer.
interface cpm_output_seq_if #(
  parameter int DATA_W = 22,
  parameter int CH_W   = 2
);
  logic [DATA_W:0]   cpm;
  logic [CH_W-1:0]   cpm_ch;
  logic              cpm_ack;

  modport master (output cpm, output cpm_ch, input cpm_ack);
  modport slave  (input cpm, input cpm_ch, output cpm_ack);
endinterface

// File: rtl/cpm_prio_enc.sv
// Lowest-set-bit priority encoder over the remaining channel mask.
module cpm_prio_enc #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  mask,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last assignment and wins.
  always_comb begin
    index = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) index = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/cpm_output_seq.sv
// Snapshots N_CH results on end_measurement and strobes each enabled channel onto the CPM bus.
module cpm_output_seq
  import cpm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_CH      = DEF_N_CH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int ACK_MODE  = 0
) (
  input  logic                   clk_200MHz,
  input  logic                   reset,
  input  logic                   end_measurement,
  input  logic [N_CH*DATA_W-1:0] result_for_cpm,
  input  logic [N_CH-1:0]        ch_enable,
  cpm_output_seq_if.master       bus,
  output logic                   access,
  output logic                   overrun,
  output logic                   ack_timeout
);

  localparam int CH_W    = ch_width(N_CH);
  localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("SETUP_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("HOLD_CYC must be >= 1");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("N_CH must be >= 1");
  end

  cpm_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   mask;
  logic [DATA_W-1:0] shadow [N_CH];
  logic [DATA_W-1:0] data;
  logic              strobe;
  logic [CH_W-1:0]   ch;
  logic              load_pend;

  logic [CH_W-1:0]   next_idx;
  logic              next_any;
  logic              capture, setup_done, hold_done;
  logic              ack_hit, fall, timeout_hit, do_load;

  cpm_prio_enc #(.N_CH(N_CH), .IDX_W(CH_W)) u_prio (
    .mask  (mask),
    .index (next_idx),
    .any   (next_any)
  );

  // access is high only while idle, so an edge that returns it to 1 still counts as busy.
  assign capture    = end_measurement && access;
  assign setup_done = (cnt == CNT_W'(SETUP_CYC - 1));
  assign hold_done  = (cnt == CNT_W'(HOLD_CYC - 1));

  // NOTE: non-blocking assignments in clocked blocks keep every register updating from pre-edge values.
  always_ff @(posedge clk_200MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (capture && |ch_enable)    state_next = SETUP;
      SETUP:   if (!load_pend && setup_done) state_next = STROBE;
      STROBE:  if (fall)                     state_next = next_any ? SETUP : IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_hit     = 1'b0;
    fall        = 1'b0;
    timeout_hit = 1'b0;
    if (state == STROBE) begin
      ack_hit     = (ACK_MODE != 0) && bus.cpm_ack;
      fall        = ack_hit || hold_done;
      timeout_hit = (ACK_MODE != 0) && !ack_hit && hold_done;
    end
    do_load = ((state == SETUP) && load_pend) || (fall && next_any);
  end

  // NOTE: the shadow bank has no reset; it is only read after a capture has written it.
  always_ff @(posedge clk_200MHz) begin
    if (capture) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= result_for_cpm[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_200MHz) begin
    if (reset) begin
      mask        <= '0;
      load_pend   <= 1'b0;
      cnt         <= '0;
      data        <= '0;
      strobe      <= 1'b0;
      ch          <= '0;
      access      <= 1'b1;
      overrun     <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      if (end_measurement && !access) overrun     <= 1'b1;
      if (timeout_hit)                ack_timeout <= 1'b1;

      if (capture) begin
        mask      <= ch_enable;
        load_pend <= |ch_enable;
        access    <= 1'b0;
      end else if ((state == IDLE) && !access) begin
        access <= 1'b1;
      end else if (fall && !next_any) begin
        access <= 1'b1;
      end

      if (do_load) begin
        data           <= shadow[next_idx];
        ch             <= next_idx;
        mask[next_idx] <= 1'b0;
        load_pend      <= 1'b0;
      end

      if ((state == SETUP) && !load_pend && setup_done) strobe <= 1'b1;
      if (fall)                                         strobe <= 1'b0;

      if (do_load || fall || ((state == SETUP) && setup_done)) cnt <= '0;
      else if (state != IDLE)                                  cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.cpm    = {strobe, data};
  assign bus.cpm_ch = ch;

endmodule

// File: tb/tb_cpm_output_seq.sv
// Bench: schedule-based model checks the fixed-window instance every cycle; directed checks pin both instances.
`timescale 1ns/1ps
module tb_cpm_output_seq;

  localparam int DW = 22;
  localparam int NC = 4;
  localparam int S  = 3;
  localparam int H  = 5;
  localparam int P  = S + H;

  logic clk_200MHz = 1'b0;
  always #5 clk_200MHz = ~clk_200MHz;

  logic           reset = 1'b1;
  logic           em0 = 1'b0, em1 = 1'b0;
  logic [NC*DW-1:0] res0 = '0, res1 = '0;
  logic [NC-1:0]  ch_en0 = '0, ch_en1 = '0;
  logic           access0, overrun0, ack_to0;
  logic           access1, overrun1, ack_to1;

  cpm_output_seq_if #(.DATA_W(DW), .CH_W(2)) bus0 ();
  cpm_output_seq_if #(.DATA_W(DW), .CH_W(2)) bus1 ();

  cpm_output_seq #(.DATA_W(DW), .N_CH(NC), .SETUP_CYC(S), .HOLD_CYC(H), .ACK_MODE(0)) dut0 (
    .clk_200MHz(clk_200MHz), .reset(reset), .end_measurement(em0),
    .result_for_cpm(res0), .ch_enable(ch_en0), .bus(bus0.master),
    .access(access0), .overrun(overrun0), .ack_timeout(ack_to0)
  );

  cpm_output_seq #(.DATA_W(DW), .N_CH(NC), .SETUP_CYC(S), .HOLD_CYC(H), .ACK_MODE(1)) dut1 (
    .clk_200MHz(clk_200MHz), .reset(reset), .end_measurement(em1),
    .result_for_cpm(res1), .ch_enable(ch_en1), .bus(bus1.master),
    .access(access1), .overrun(overrun1), .ack_timeout(ack_to1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a snapshot at cycle T with M enabled channels lays out a fixed timeline.
  int          cyc = 0;
  logic [DW-1:0] e_data = '0;
  int          e_ch = 0;
  logic        e_stb = 1'b0, e_acc = 1'b1, e_ovr = 1'b0;

  initial begin
    int          t0, tend, m, st;
    bit          act;
    int          ord[$];
    logic [DW-1:0] snap [NC];
    act = 1'b0;
    t0  = 0;
    forever begin
      @(posedge clk_200MHz);
      cyc++;
      if (reset) begin
        e_data = '0; e_ch = 0; e_stb = 1'b0; e_acc = 1'b1; e_ovr = 1'b0; act = 1'b0;
      end else begin
        if (em0) begin
          if (e_acc) begin
            t0 = cyc;
            ord.delete();
            for (int i = 0; i < NC; i++) begin
              snap[i] = res0[i*DW +: DW];
              if (ch_en0[i]) ord.push_back(i);
            end
            act = 1'b1;
          end else begin
            e_ovr = 1'b1;
          end
        end
        if (act) begin
          m     = ord.size();
          tend  = t0 + 1 + m * P;
          e_acc = (cyc >= tend);
          e_stb = 1'b0;
          for (int k = 0; k < m; k++) begin
            st = t0 + 1 + k * P;
            if (cyc >= st) begin
              e_ch   = ord[k];
              e_data = snap[ord[k]];
            end
            if (cyc >= st + S && cyc < st + S + H) e_stb = 1'b1;
          end
          if (cyc >= tend) act = 1'b0;
        end
      end
      @(negedge clk_200MHz);
      check($sformatf("model_data@%0d", cyc), 32'(bus0.cpm[DW-1:0]), 32'(e_data));
      check($sformatf("model_strobe@%0d", cyc), 32'(bus0.cpm[DW]), 32'(e_stb));
      check($sformatf("model_ch@%0d", cyc), 32'(bus0.cpm_ch), 32'(e_ch));
      check($sformatf("model_access@%0d", cyc), 32'(access0), 32'(e_acc));
      check($sformatf("model_overrun@%0d", cyc), 32'(overrun0), 32'(e_ovr));
      check($sformatf("model_ack_timeout@%0d", cyc), 32'(ack_to0), 32'd0);
    end
  end

  // Directed stimulus; rel counts edges since the snapshot edge T.
  int rel = 0;

  task automatic goto(input int n);
    repeat (n - rel) @(posedge clk_200MHz);
    rel = n;
    @(negedge clk_200MHz);
  endtask

  task automatic start0(input logic [NC-1:0] m);
    em0 = 1'b1; ch_en0 = m;
    @(posedge clk_200MHz);
    rel = 0;
    @(negedge clk_200MHz);
    em0 = 1'b0;
  endtask

  task automatic start1(input logic [NC-1:0] m);
    em1 = 1'b1; ch_en1 = m;
    @(posedge clk_200MHz);
    rel = 0;
    @(negedge clk_200MHz);
    em1 = 1'b0;
  endtask

  initial begin
    bus1.cpm_ack = 1'b0;
    bus0.cpm_ack = 1'b0;
    repeat (2) @(posedge clk_200MHz);
    @(negedge clk_200MHz);
    check("reset_cpm0", 32'(bus0.cpm), 32'd0);
    check("reset_access0", 32'(access0), 32'd1);
    check("reset_flags1", 32'({overrun1, ack_to1}), 32'd0);
    reset = 1'b0;

    // All four channels, in order, with an ignored pulse at T+10.
    res0 = {22'h44, 22'h33, 22'h22, 22'h11};
    start0(4'b1111);
    check("A_access_T", 32'(access0), 32'd0);
    goto(1);  check("A_ch_T1", 32'(bus0.cpm_ch), 32'd0);
              check("A_data_T1", 32'(bus0.cpm[DW-1:0]), 32'h11);
    goto(3);  check("A_strobe_T3", 32'(bus0.cpm[DW]), 32'd0);
    goto(4);  check("A_strobe_T4", 32'(bus0.cpm[DW]), 32'd1);
    goto(8);  check("A_strobe_T8", 32'(bus0.cpm[DW]), 32'd1);
    goto(9);  check("A_ch_T9", 32'(bus0.cpm_ch), 32'd1);
              check("A_data_T9", 32'(bus0.cpm[DW-1:0]), 32'h22);
              em0 = 1'b1; ch_en0 = 4'b0001; res0 = {4{22'h3F}};
    goto(10); em0 = 1'b0;
              check("A_overrun_T10", 32'(overrun0), 32'd1);
    goto(17); check("A_ch_T17", 32'(bus0.cpm_ch), 32'd2);
              check("A_data_T17", 32'(bus0.cpm[DW-1:0]), 32'h33);
    goto(25); check("A_data_T25", 32'(bus0.cpm[DW-1:0]), 32'h44);
    goto(32); check("A_access_T32", 32'(access0), 32'd0);
    goto(33); check("A_access_T33", 32'(access0), 32'd1);
    reset = 1'b1;
    goto(34); reset = 1'b0;
    check("A_reset_overrun", 32'(overrun0), 32'd0);

    // Channels 1 and 3 only; pulse on the access-return edge.
    res0 = {22'h30004, 22'h20003, 22'h10002, 22'h00001};
    start0(4'b1010);
    goto(1);  check("B_ch_T1", 32'(bus0.cpm_ch), 32'd1);
              check("B_data_T1", 32'(bus0.cpm[DW-1:0]), 32'h10002);
    goto(9);  check("B_ch_T9", 32'(bus0.cpm_ch), 32'd3);
              check("B_data_T9", 32'(bus0.cpm[DW-1:0]), 32'h30004);
    goto(16); check("B_access_T16", 32'(access0), 32'd0);
              em0 = 1'b1;
    goto(17); em0 = 1'b0;
              check("B_access_T17", 32'(access0), 32'd1);
              check("B_overrun_T17", 32'(overrun0), 32'd1);
    goto(19); check("B_access_T19", 32'(access0), 32'd1);

    // Empty mask: access drops for one cycle, no strobe, data held.
    start0(4'b0000);
    check("C_access_T", 32'(access0), 32'd0);
    goto(1);  check("C_access_T1", 32'(access0), 32'd1);
    goto(8);  check("C_strobe_T8", 32'(bus0.cpm[DW]), 32'd0);
              check("C_ch_hold", 32'(bus0.cpm_ch), 32'd3);

    // Reset during STROBE, then a fresh sequence restarts from channel 0.
    res0 = {22'h44, 22'h33, 22'h22, 22'h11};
    start0(4'b1111);
    goto(5);  check("D_strobe_T5", 32'(bus0.cpm[DW]), 32'd1);
              reset = 1'b1;
    goto(6);  reset = 1'b0;
              check("D_reset_cpm", 32'(bus0.cpm), 32'd0);
              check("D_reset_ch", 32'(bus0.cpm_ch), 32'd0);
              check("D_reset_access", 32'(access0), 32'd1);
              check("D_reset_overrun", 32'(overrun0), 32'd0);
    res0 = {22'hD4, 22'hC3, 22'hB2, 22'hA1};
    start0(4'b1111);
    goto(1);  check("D_ch_restart", 32'(bus0.cpm_ch), 32'd0);
              check("D_data_restart", 32'(bus0.cpm[DW-1:0]), 32'hA1);
    goto(4);  check("D_strobe_restart", 32'(bus0.cpm[DW]), 32'd1);
    goto(40);

    // Ack mode: early ack in SETUP ignored, ack ends strobe 0, timeout ends strobe 1.
    res1 = {22'h0, 22'h0, 22'h5678, 22'h1234};
    start1(4'b0011);
    goto(1);  bus1.cpm_ack = 1'b1;
    goto(2);  bus1.cpm_ack = 1'b0;
    goto(3);  check("E_strobe_T3", 32'(bus1.cpm[DW]), 32'd0);
    goto(4);  check("E_strobe_T4", 32'(bus1.cpm[DW]), 32'd1);
              check("E_data_T4", 32'(bus1.cpm[DW-1:0]), 32'h1234);
    goto(5);  check("E_strobe_T5", 32'(bus1.cpm[DW]), 32'd1);
              bus1.cpm_ack = 1'b1;
    goto(6);  bus1.cpm_ack = 1'b0;
              check("E_strobe_ack", 32'(bus1.cpm[DW]), 32'd0);
              check("E_ch_ack", 32'(bus1.cpm_ch), 32'd1);
              check("E_data_ack", 32'(bus1.cpm[DW-1:0]), 32'h5678);
              check("E_timeout_ack", 32'(ack_to1), 32'd0);
    goto(9);  check("E_strobe_T9", 32'(bus1.cpm[DW]), 32'd1);
    goto(13); check("E_strobe_T13", 32'(bus1.cpm[DW]), 32'd1);
              check("E_timeout_T13", 32'(ack_to1), 32'd0);
              check("E_access_T13", 32'(access1), 32'd0);
    goto(14); check("E_strobe_T14", 32'(bus1.cpm[DW]), 32'd0);
              check("E_timeout_T14", 32'(ack_to1), 32'd1);
              check("E_access_T14", 32'(access1), 32'd1);
              check("E_overrun", 32'(overrun1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

endmodule
